si_mpy_seq: RTL and testbench

SI_MPY_SEQ -- requirements
Module: si_mpy_seq

---
 rtl/si_mpy_pkg.sv | 22 ++
 rtl/si_mpy_sat.sv | 33 +++
 rtl/si_mpy_seq.sv | 137 +++++++++++++
 tb/tb_si_mpy_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/si_mpy_pkg.sv
`default_nettype none
// si_mpy_pkg -- shared FSM state type and legal configuration range for si_mpy_seq.
// Rev 1.0
package si_mpy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 32;
   localparam int FRAC_MIN  = 0;

   function automatic bit cfg_ok(input int width, input int frac);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             (frac >= FRAC_MIN) && (frac < width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/si_mpy_sat.sv
`default_nettype none
// si_mpy_sat -- sign restore, fixed-point rescale and overflow/saturation of a product magnitude.
// Rev 1.0. Saturation is enabled by macro SI_MPY_SEQ_SAT_EN; otherwise the result wraps.
module si_mpy_sat #(
   parameter int WIDTH = 8,
   parameter int FRAC  = 0
) (
   input  logic [2*WIDTH-1:0] prod_mag,
   input  logic               sign,
   output logic [WIDTH-1:0]   result,
   output logic               ovf
);

   logic signed [2*WIDTH-1:0] prod_s;
   logic signed [2*WIDTH-1:0] shifted;

   always_comb begin
      // Magnitude never exceeds 2^(2W-2), so it negates safely within 2W bits
      prod_s  = sign ? -$signed(prod_mag) : $signed(prod_mag);
      shifted = prod_s >>> FRAC;
      ovf     = !((&shifted[2*WIDTH-1:WIDTH-1]) || (~|shifted[2*WIDTH-1:WIDTH-1]));
`ifdef SI_MPY_SEQ_SAT_EN
      if (ovf)
         result = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         result = shifted[WIDTH-1:0];
`else
      result = shifted[WIDTH-1:0];
`endif
   end

endmodule
`default_nettype wire

// File: rtl/si_mpy_seq.sv
`default_nettype none
// si_mpy_seq -- sequential signed fixed-point multiplier, one radix-2 step per cycle.
// Rev 1.0. Optional saturation via macro SI_MPY_SEQ_SAT_EN.
module si_mpy_seq
   import si_mpy_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FRAC  = 0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] A_MPY_B,
   output logic             OVF
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   if (!cfg_ok(WIDTH, FRAC)) begin : g_cfg_check
      $error("si_mpy_seq: WIDTH/FRAC out of legal range");
   end

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       a_mag_q, a_mag_d;
   logic                   sign_q, sign_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       res_q, res_d;
   logic                   ovf_q, ovf_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;

   logic [WIDTH:0]         upper_sum;
   logic [2*WIDTH-1:0]     acc_step;
   logic [WIDTH-1:0]       b_mag;
   logic [WIDTH-1:0]       sat_res;
   logic                   sat_ovf;

   si_mpy_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_sat (
      .prod_mag (acc_step),
      .sign     (sign_q),
      .result   (sat_res),
      .ovf      (sat_ovf)
   );

   always_comb begin
      // Multiplier starts in the low half and shifts out as the product shifts in
      upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
      acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
      b_mag     = B[WIDTH-1] ? (~B + 1'b1) : B;

      state_d     = state_q;
      a_mag_d     = a_mag_q;
      sign_d      = sign_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               a_mag_d    = A[WIDTH-1] ? (~A + 1'b1) : A;
               acc_d      = {{WIDTH{1'b0}}, b_mag};
               sign_d     = A[WIDTH-1] ^ B[WIDTH-1];
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = MUL;
            end
         end
         MUL: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               res_d       = sat_res;
               ovf_d       = sat_ovf;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (OUT_READY) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         a_mag_q     <= '0;
         sign_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_mag_q     <= a_mag_d;
         sign_q      <= sign_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign A_MPY_B   = res_q;
   assign OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_si_mpy_seq.sv
`default_nettype none
// tb_si_mpy_seq -- directed checks of si_mpy_seq at WIDTH=8 with FRAC=0 and FRAC=4.
// Rev 1.0. Expected values follow SI_MPY_SEQ_SAT_EN when it is defined.
module tb_si_mpy_seq;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_valid;
   logic [1:0] in_ready;
   logic [1:0] out_valid;
   logic [1:0] out_ready;
   logic [1:0] ovf;
   logic [7:0] a_in   [2];
   logic [7:0] b_in   [2];
   logic [7:0] result [2];

   int compared   = 0;
   int mismatched = 0;

   si_mpy_seq #(.WIDTH(8), .FRAC(0)) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .IN_VALID  (in_valid[0]),
      .IN_READY  (in_ready[0]),
      .A         (a_in[0]),
      .B         (b_in[0]),
      .OUT_VALID (out_valid[0]),
      .OUT_READY (out_ready[0]),
      .A_MPY_B   (result[0]),
      .OVF       (ovf[0])
   );

   si_mpy_seq #(.WIDTH(8), .FRAC(4)) u_dut_f4 (
      .CLK       (clk),
      .RST_N     (rst_n),
      .IN_VALID  (in_valid[1]),
      .IN_READY  (in_ready[1]),
      .A         (a_in[1]),
      .B         (b_in[1]),
      .OUT_VALID (out_valid[1]),
      .OUT_READY (out_ready[1]),
      .A_MPY_B   (result[1]),
      .OVF       (ovf[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one operand pair from IDLE and checks latency, result and flag.
   task automatic run(input int s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic eo, input string tag);
      int lat;
      a_in[s]     = a;
      b_in[s]     = b;
      in_valid[s] = 1'b1;
      @(posedge clk); #1;
      in_valid[s] = 1'b0;
      lat = 1;
      while (!out_valid[s] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 9);
      check({tag, "_result"}, result[s], er);
      check({tag, "_ovf"}, ovf[s], eo);
      if (out_ready[s]) begin
         @(posedge clk); #1;
         check({tag, "_ready_again"}, in_ready[s], 1'b1);
      end
   endtask

   logic [7:0] exp_10x21, exp_m10x21, exp_m128sq, exp_f4_big;
   bit         seen_valid;

   initial begin
`ifdef SI_MPY_SEQ_SAT_EN
      exp_10x21  = 8'h7F;
      exp_m10x21 = 8'h80;
      exp_m128sq = 8'h7F;
      exp_f4_big = 8'h7F;
`else
      exp_10x21  = 8'hD2;
      exp_m10x21 = 8'h2E;
      exp_m128sq = 8'h00;
      exp_f4_big = 8'hF0;
`endif
      rst_n     = 1'b0;
      in_valid  = 2'b00;
      out_ready = 2'b11;
      a_in[0] = '0; b_in[0] = '0; a_in[1] = '0; b_in[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready[0], 1'b1);
      check("rst_out_valid", out_valid[0], 1'b0);
      check("rst_result", result[0], 8'h00);
      check("rst_ovf", ovf[0], 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(0, 8'd3,   8'd5,   8'd15,      1'b0, "3x5");
      run(0, 8'd13,  8'hFF,  8'hF3,      1'b0, "13xm1");
      run(0, 8'hFB,  8'hFE,  8'd10,      1'b0, "m5xm2");
      run(0, 8'd10,  8'd21,  exp_10x21,  1'b1, "10x21");
      run(0, 8'hF6,  8'd21,  exp_m10x21, 1'b1, "m10x21");
      run(0, 8'h80,  8'h80,  exp_m128sq, 1'b1, "m128xm128");
      run(0, 8'h80,  8'h01,  8'h80,      1'b0, "m128x1");
      run(0, 8'h00,  8'h7F,  8'h00,      1'b0, "0x127");

      run(1, 8'h18,  8'h28,  8'h3C,      1'b0, "f4_1p5x2p5");
      run(1, 8'hFF,  8'h01,  8'hFF,      1'b0, "f4_floor");
      run(1, 8'h7F,  8'h7F,  exp_f4_big, 1'b1, "f4_big");

      // Consumer stalls while a new operand pair is offered
      out_ready[0] = 1'b0;
      run(0, 8'd3, 8'd5, 8'd15, 1'b0, "stall");
      a_in[0] = 8'd7; b_in[0] = 8'd7; in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_result", result[0], 8'd15);
         check("stall_out_valid", out_valid[0], 1'b1);
         check("stall_in_ready", in_ready[0], 1'b0);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", out_valid[0], 1'b0);
      check("release_in_ready", in_ready[0], 1'b1);

      // Reset on the third MUL cycle discards the operation
      a_in[0] = 8'd6; b_in[0] = 8'd7; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", in_ready[0], 1'b1);
      check("midrst_out_valid", out_valid[0], 1'b0);
      check("midrst_result", result[0], 8'h00);
      check("midrst_ovf", ovf[0], 1'b0);
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen_valid = 1'b1;
      end
      check("midrst_no_valid", seen_valid, 1'b0);
      run(0, 8'd6, 8'hF9, 8'hD6, 1'b0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
